mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the CPU's single-port 19-bit memory. The instruction-fetch port and the data load/store port share one memory instance. The arbiter accepts one access per grant, drives the memory strobes and waits out the fixed read latency. It then routes the read word back to the port that owns the access. It sits between the fetch/load-store logic and the memory array in the CPU top level.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_pick2.sv | 27 ++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int LAT_MAX = 4;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

endpackage

// File: rtl/mem_port_arbiter_pick2.sv
// Combinational two-input picker: fixed data-over-fetch priority, or
// round-robin on a tie when rr_sel is set.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic  if_req,
  input  logic  d_req,
  input  logic  rr_sel,
  input  port_e last_gnt,
  output logic  if_pick,
  output logic  d_pick
);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    if_pick = 1'b0;
    d_pick  = 1'b0;
    if (if_req && d_req) begin
      if (rr_sel && (last_gnt == PORT_D)) if_pick = 1'b1;
      else                                d_pick  = 1'b1;
    end else begin
      if_pick = if_req;
      d_pick  = d_req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter and read sequencer for a single-port memory.
// Define MEM_ARB_RR_EN for round-robin arbitration on ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 8,
  parameter int DW  = 19,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  port_e            owner_q, owner_d;
  port_e            last_gnt;
  logic             rr_sel;
  logic             final_wait, arb_en, if_pick, d_pick, read_gnt;

  assign final_wait = (state_q == WAIT) && (cnt_q == CNT_W'(1));
  // Grants are suppressed while reset is held so outputs stay quiet.
  assign arb_en     = rst && ((state_q == IDLE) || final_wait);

`ifdef MEM_ARB_RR_EN
  port_e last_q, last_d;

  assign rr_sel   = 1'b1;
  assign last_gnt = last_q;

  always_comb begin
    last_d = last_q;
    if (if_pick)     last_d = PORT_IF;
    else if (d_pick) last_d = PORT_D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= PORT_IF;
    else      last_q <= last_d;
  end
`else
  assign rr_sel   = 1'b0;
  assign last_gnt = PORT_IF;
`endif

  arb_pick2 u_pick (
    .if_req   (if_req && arb_en),
    .d_req    (d_req && arb_en),
    .rr_sel   (rr_sel),
    .last_gnt (last_gnt),
    .if_pick  (if_pick),
    .d_pick   (d_pick)
  );

  assign if_gnt   = if_pick;
  assign d_gnt    = d_pick;
  assign mem_en   = if_pick || d_pick;
  assign mem_we   = d_pick && d_we;
  assign read_gnt = if_pick || (d_pick && !d_we);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_pick) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_pick) begin
      mem_addr  = if_addr;
    end
  end

  assign if_rvalid = final_wait && (owner_q == PORT_IF);
  assign d_rvalid  = final_wait && (owner_q == PORT_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;
  assign busy      = (state_q == WAIT);

  // A read grant in the final WAIT cycle reloads the counter, giving
  // back-to-back reads every LAT cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    if (read_gnt) begin
      state_d = WAIT;
      cnt_d   = CNT_W'(LAT);
      owner_d = d_pick ? PORT_D : PORT_IF;
    end else if (state_q == WAIT) begin
      if (final_wait) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= PORT_IF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: LAT=2 instance driven from a vector table with
// a read-data scoreboard, plus a LAT=1 instance for priority / tie sequences.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 8;
  localparam int DW   = 19;
  localparam int LAT2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // LAT=2 instance signals
  logic          if_req2 = 0, d_req2 = 0, d_we2 = 0;
  logic [AW-1:0] if_addr2 = 0, d_addr2 = 0;
  logic [DW-1:0] d_wdata2 = 0;
  logic          if_gnt2, if_rvalid2, d_gnt2, d_rvalid2, mem_en2, mem_we2, busy2;
  logic [DW-1:0] if_rdata2, d_rdata2, mem_wdata2, mem_rdata2;
  logic [AW-1:0] mem_addr2;

  // LAT=1 instance signals
  logic          if_req1 = 0, d_req1 = 0, d_we1 = 0;
  logic [AW-1:0] if_addr1 = 8'h08, d_addr1 = 8'h10;
  logic [DW-1:0] d_wdata1 = 0;
  logic          if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, busy1;
  logic [DW-1:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [AW-1:0] mem_addr1;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT2)) u_dut2 (
    .clk(clk), .rst(rst),
    .if_req(if_req2), .if_addr(if_addr2), .if_gnt(if_gnt2),
    .if_rvalid(if_rvalid2), .if_rdata(if_rdata2),
    .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .busy(busy2)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  // Memory models: synchronous write, read data delayed by LAT cycles.
  logic [DW-1:0] mem2 [256];
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] pipe2 [2];
  logic [DW-1:0] pipe1;
  logic [DW-1:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_en2 && mem_we2) mem2[mem_addr2] <= mem_wdata2;
    pipe2[0] <= mem2[mem_addr2];
    pipe2[1] <= pipe2[0];
    if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_wdata1;
    pipe1 <= mem1[mem_addr1];
  end
  assign mem_rdata2 = pipe2[1];
  assign mem_rdata1 = pipe1;

  // Requesters must hold req until granted.
  a_if2_hold: assert property (@(posedge clk) disable iff (!rst) (if_req2 && !if_gnt2) |=> if_req2);
  a_d2_hold:  assert property (@(posedge clk) disable iff (!rst) (d_req2 && !d_gnt2) |=> d_req2);
  a_if1_hold: assert property (@(posedge clk) disable iff (!rst) (if_req1 && !if_gnt1) |=> if_req1);
  a_d1_hold:  assert property (@(posedge clk) disable iff (!rst) (d_req1 && !d_gnt1) |=> d_req1);

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          e_if;
    logic          e_d;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic          e_busy;
  } vec_t;

  typedef struct {
    port_e         port;
    logic [DW-1:0] data;
    int            due;
  } sb_t;

  vec_t tab[$];
  sb_t  sb[$];

  function automatic vec_t v(logic r, logic ir, logic [AW-1:0] ia, logic dr, logic dwe,
                             logic [AW-1:0] da, logic [DW-1:0] dwd, logic eif, logic ed,
                             logic ewe, logic [AW-1:0] ea, logic eb);
    vec_t t;
    t.rst = r; t.if_req = ir; t.if_addr = ia; t.d_req = dr; t.d_we = dwe;
    t.d_addr = da; t.d_wdata = dwd; t.e_if = eif; t.e_d = ed; t.e_we = ewe;
    t.e_addr = ea; t.e_busy = eb;
    return t;
  endfunction

  function automatic vec_t idle(logic eb);
    return v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eb);
  endfunction

  task automatic step1(input logic ir, input logic dr);
    @(posedge clk); #1;
    if_req1 = ir;
    d_req1  = dr;
    @(negedge clk);
  endtask

  initial begin
    vec_t          t;
    sb_t           e;
    logic [1:0]    exp_rv;
    port_e         order[4];
    logic          pend_if, pend_d;

    for (int a = 0; a < 256; a++) begin
      mem2[a] = '0; mem1[a] = '0; ref_mem[a] = '0;
    end
    mem2[8'h05] = 19'h1ABCD; ref_mem[8'h05] = 19'h1ABCD;
    mem2[8'h40] = 19'h00777; ref_mem[8'h40] = 19'h00777;
    mem1[8'h10] = 19'h12345;
    mem1[8'h08] = 19'h0BEEF;

    tab.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(idle(0));
    // single fetch, LAT=2
    tab.push_back(v(1, 1, 8'h05, 0, 0, 0, 0, 1, 0, 0, 8'h05, 0));
    tab.push_back(idle(1));
    tab.push_back(idle(1));
    tab.push_back(idle(0));
    // back-to-back stores then readback
    tab.push_back(v(1, 0, 0, 1, 1, 8'h20, 19'd1, 0, 1, 1, 8'h20, 0));
    tab.push_back(v(1, 0, 0, 1, 1, 8'h21, 19'd2, 0, 1, 1, 8'h21, 0));
    tab.push_back(v(1, 0, 0, 1, 1, 8'h22, 19'd3, 0, 1, 1, 8'h22, 0));
    tab.push_back(v(1, 0, 0, 1, 0, 8'h20, 0, 0, 1, 0, 8'h20, 0));
    tab.push_back(v(1, 0, 0, 1, 0, 8'h21, 0, 0, 0, 0, 0, 1));
    tab.push_back(v(1, 0, 0, 1, 0, 8'h21, 0, 0, 1, 0, 8'h21, 1));
    tab.push_back(v(1, 0, 0, 1, 0, 8'h22, 0, 0, 0, 0, 0, 1));
    tab.push_back(v(1, 0, 0, 1, 0, 8'h22, 0, 0, 1, 0, 8'h22, 1));
    tab.push_back(idle(1));
    tab.push_back(idle(1));
    // fetch, then store racing a fetch: store wins, fetch follows next cycle
    tab.push_back(v(1, 1, 8'h40, 0, 0, 0, 0, 1, 0, 0, 8'h40, 0));
    tab.push_back(idle(1));
    tab.push_back(idle(1));
    tab.push_back(v(1, 1, 8'h05, 1, 1, 8'h30, 19'h5A5A5, 0, 1, 1, 8'h30, 0));
    tab.push_back(v(1, 1, 8'h05, 0, 0, 0, 0, 1, 0, 0, 8'h05, 0));
    tab.push_back(idle(1));
    tab.push_back(idle(1));
    tab.push_back(v(1, 0, 0, 1, 0, 8'h30, 0, 0, 1, 0, 8'h30, 0));
    tab.push_back(idle(1));
    tab.push_back(idle(1));
    tab.push_back(idle(0));
    // reset in the middle of a fetch
    tab.push_back(v(1, 1, 8'h05, 0, 0, 0, 0, 1, 0, 0, 8'h05, 0));
    tab.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(idle(0));
    tab.push_back(v(1, 1, 8'h40, 0, 0, 0, 0, 1, 0, 0, 8'h40, 0));
    tab.push_back(idle(1));
    tab.push_back(idle(1));
    tab.push_back(idle(0));

    for (int i = 0; i < tab.size(); i++) begin
      t = tab[i];
      @(posedge clk); #1;
      rst = t.rst; if_req2 = t.if_req; if_addr2 = t.if_addr;
      d_req2 = t.d_req; d_we2 = t.d_we; d_addr2 = t.d_addr; d_wdata2 = t.d_wdata;
      @(negedge clk);

      check($sformatf("row%0d ctrl", i), {if_gnt2, d_gnt2, mem_en2, mem_we2, busy2},
            {t.e_if, t.e_d, t.e_if | t.e_d, t.e_we, t.e_busy});
      if (t.e_if || t.e_d || !t.rst)
        check($sformatf("row%0d mem_addr", i), mem_addr2, t.e_addr);
      if (t.e_we || !t.rst)
        check($sformatf("row%0d mem_wdata", i), mem_wdata2, t.rst ? t.d_wdata : '0);
      if (!t.rst) begin
        sb.delete();
        check($sformatf("row%0d rdata_rst", i), {if_rdata2, d_rdata2}, 0);
      end

      exp_rv = 2'b00;
      if (sb.size() > 0 && sb[0].due == i) exp_rv = (sb[0].port == PORT_IF) ? 2'b10 : 2'b01;
      check($sformatf("row%0d rvalid", i), {if_rvalid2, d_rvalid2}, exp_rv);
      if (exp_rv != 2'b00) begin
        e = sb.pop_front();
        check($sformatf("row%0d rdata", i), (e.port == PORT_IF) ? if_rdata2 : d_rdata2, e.data);
      end

      if (t.e_if) sb.push_back('{PORT_IF, ref_mem[t.if_addr], i + LAT2});
      if (t.e_d && !t.d_we) sb.push_back('{PORT_D, ref_mem[t.d_addr], i + LAT2});
      if (t.e_d && t.d_we) ref_mem[t.d_addr] = t.d_wdata;
    end
    check("sb drained", sb.size(), 0);

    @(posedge clk); #1;
    if_req2 = 0; d_req2 = 0; d_we2 = 0;

    // Fixed-priority tie on the LAT=1 instance.
    step1(1, 1);
    check("t2 c0 gnt", {if_gnt1, d_gnt1}, 2'b01);
    check("t2 c0 rvalid", {if_rvalid1, d_rvalid1}, 2'b00);
    step1(1, 0);
    check("t2 c1 gnt", {if_gnt1, d_gnt1}, 2'b10);
    check("t2 c1 rvalid", {if_rvalid1, d_rvalid1}, 2'b01);
    check("t2 c1 d_rdata", d_rdata1, 19'h12345);
    check("t2 c1 mem_addr", mem_addr1, 8'h08);
    step1(0, 0);
    check("t2 c2 rvalid", {if_rvalid1, d_rvalid1}, 2'b10);
    check("t2 c2 if_rdata", if_rdata1, 19'h0BEEF);
    check("t2 c2 busy", busy1, 1'b1);

    // Continuous contention: last grant was fetch, so data wins first in both modes.
`ifdef MEM_ARB_RR_EN
    order = '{PORT_D, PORT_IF, PORT_D, PORT_IF};
`else
    order = '{PORT_D, PORT_D, PORT_D, PORT_D};
`endif
    for (int k = 0; k < 4; k++) begin
      step1(1, 1);
      check($sformatf("t3 k%0d gnt", k), {if_gnt1, d_gnt1},
            (order[k] == PORT_IF) ? 2'b10 : 2'b01);
      if (k == 0) exp_rv = 2'b00;
      else        exp_rv = (order[k-1] == PORT_IF) ? 2'b10 : 2'b01;
      check($sformatf("t3 k%0d rvalid", k), {if_rvalid1, d_rvalid1}, exp_rv);
      if (k > 0)
        check($sformatf("t3 k%0d rdata", k), (order[k-1] == PORT_IF) ? if_rdata1 : d_rdata1,
              (order[k-1] == PORT_IF) ? 19'h0BEEF : 19'h12345);
    end
    pend_if = (order[3] != PORT_IF);
    pend_d  = (order[3] != PORT_D);
    step1(pend_if, pend_d);
    check("t3 drain gnt", {if_gnt1, d_gnt1}, {pend_if, pend_d});
    check("t3 drain rvalid", {if_rvalid1, d_rvalid1}, (order[3] == PORT_IF) ? 2'b10 : 2'b01);
    step1(0, 0);
    check("t3 last rvalid", {if_rvalid1, d_rvalid1}, {pend_if, pend_d});
    step1(0, 0);
    check("t3 idle", {if_rvalid1, d_rvalid1, busy1}, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
